// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: fractional-accumulator baud tick, 3-sample majority filter,
// parity/stop/break checking, held character with valid/ack, idle-gap and end-of-packet flags.
`timescale 1ns/1ps
module uart_rx_cfg #(
   parameter int CLK_FREQ     = 12000000,
   parameter int BAUD         = 115200,
   parameter int OVERSAMPLING = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int GAP_BITS     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ack,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun,
   output logic                 RxD_idle,
   output logic                 RxD_endofpacket
);

   localparam int              PH_W      = $clog2(OVERSAMPLING);
   localparam int              GAP_MAX   = GAP_BITS * OVERSAMPLING;
   localparam int              GAP_W     = $clog2(GAP_MAX + 1);
   localparam logic [32:0]     INC       = 33'(BAUD * OVERSAMPLING);
   localparam logic [32:0]     MODULUS   = 33'(CLK_FREQ);
   localparam logic [PH_W-1:0] SAMPLE_PH = PH_W'(OVERSAMPLING / 2 - 1);
   localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(GAP_MAX);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_e;

   state_e               state_q, state_d;
   logic [31:0]          acc_q, acc_d;
   logic [32:0]          acc_sum;
   logic                 tick;
   logic [1:0]           sync_q, sync_d;
   logic [2:0]           win_q, win_d;
   logic                 filt;
   logic [PH_W-1:0]      phase_q, phase_d;
   logic                 samp;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bit_q, par_bit_d;
   logic                 seen_one_q, seen_one_d;
   logic                 stop_err_q, stop_err_d;
   logic                 deliver_q, deliver_d;
   logic                 brk_q, brk_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic                 eop_q, eop_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 par_calc;

   // Fractional baud tick: the accumulator never exceeds CLK_FREQ, so 33 bits cannot overflow.
   always_comb begin
      acc_sum = {1'b0, acc_q} + INC;
      tick    = (acc_sum >= MODULUS);
      acc_d   = tick ? 32'(acc_sum - MODULUS) : acc_sum[31:0];
   end

   always_comb begin
      sync_d  = {sync_q[0], RxD};
      win_d   = tick ? {win_q[1:0], sync_q[1]} : win_q;
      filt    = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);
      phase_d = (state_q == S_IDLE) ? '0 : (tick ? phase_q + 1'b1 : phase_q);
      samp    = tick && (phase_q == SAMPLE_PH);
   end

   // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (!filt) state_d = S_START;
         S_START:  if (samp) state_d = filt ? S_IDLE : S_DATA;
         S_DATA:   if (samp && bit_cnt_q == 4'(DATA_BITS - 1))
                      state_d = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (samp) state_d = S_STOP;
         S_STOP:   if (samp && bit_cnt_q == 4'(STOP_BITS - 1))
                      state_d = (seen_one_q || filt) ? S_IDLE : S_BREAK;
         S_BREAK:  if (filt) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      deliver_d = (state_q == S_STOP) && (state_d == S_IDLE);
      brk_d     = (state_q == S_STOP) && (state_d == S_BREAK);
   end

   // seen_one tracks whether any data, parity or stop sample was high; none means a break.
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_bit_d  = par_bit_q;
      seen_one_d = seen_one_q;
      stop_err_d = stop_err_q;
      if (samp) begin
         case (state_q)
            S_DATA: begin
               shift_d    = {filt, shift_q[DATA_BITS-1:1]};
               bit_cnt_d  = bit_cnt_q + 1'b1;
               seen_one_d = seen_one_q | filt;
            end
            S_PARITY: begin
               par_bit_d  = filt;
               seen_one_d = seen_one_q | filt;
            end
            S_STOP: begin
               bit_cnt_d  = bit_cnt_q + 1'b1;
               seen_one_d = seen_one_q | filt;
               stop_err_d = stop_err_q | ~filt;
            end
            default: ;
         endcase
      end
      if (state_d != state_q) bit_cnt_d = '0;
      if (state_q == S_IDLE && !filt) begin
         seen_one_d = 1'b0;
         stop_err_d = 1'b0;
      end
   end

   assign par_calc = (PARITY != 0) && ((^shift_q ^ par_bit_q) != (PARITY == 1));

   // An ack in the delivery clock frees the register, so the new character loads without overrun.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      ovr_d      = ovr_q;
      if (rx_ack && rx_valid_q) begin
         rx_valid_d = 1'b0;
         perr_d     = 1'b0;
         ferr_d     = 1'b0;
         ovr_d      = 1'b0;
      end
      if (deliver_q) begin
         if (!rx_valid_q || rx_ack) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            perr_d     = par_calc;
            ferr_d     = stop_err_q;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_comb begin
      gap_d = gap_q;
      if (state_q != S_IDLE)               gap_d = '0;
      else if (tick && gap_q != GAP_FULL)  gap_d = gap_q + 1'b1;
      eop_d = (gap_q != GAP_FULL) && (gap_d == GAP_FULL);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         sync_q     <= 2'b11;
         win_q      <= 3'b111;
         phase_q    <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_bit_q  <= 1'b0;
         seen_one_q <= 1'b0;
         stop_err_q <= 1'b0;
         deliver_q  <= 1'b0;
         brk_q      <= 1'b0;
         gap_q      <= '0;
         eop_q      <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         sync_q     <= sync_d;
         win_q      <= win_d;
         phase_q    <= phase_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_bit_q  <= par_bit_d;
         seen_one_q <= seen_one_d;
         stop_err_q <= stop_err_d;
         deliver_q  <= deliver_d;
         brk_q      <= brk_d;
         gap_q      <= gap_d;
         eop_q      <= eop_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign rx_data         = rx_data_q;
   assign rx_valid        = rx_valid_q;
   assign parity_err      = perr_q;
   assign frame_err       = ferr_q;
   assign break_det       = brk_q;
   assign overrun         = ovr_q;
   assign RxD_idle        = (gap_q == GAP_FULL);
   assign RxD_endofpacket = eop_q;

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver used on the tracker's command/config serial links. It supports a configurable data width, parity mode and stop-bit count, with a fractional-accumulator baud tick. It reports framing, parity, break and overrun errors, and holds each character in an output register with a valid/ack handshake. Idle-gap and end-of-packet detection are kept so downstream packet parsers are unchanged.

Parameters:
CLK_FREQ, 12000000, system clock in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLING, 16, ticks per bit; power of 2, 8..32; CLK_FREQ >= BAUD*OVERSAMPLING
DATA_BITS, 8, character width 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2 stop bits checked
GAP_BITS, 2, idle bit-times with no start bit before RxD_idle asserts

Ports:
clk  in  1  system clock
rst_n  in  1  reset
RxD  in  1  asynchronous serial line, idles high
rx_data  out  DATA_BITS  held character
rx_valid  out  1  rx_data holds an unacknowledged character
rx_ack  in  1  consumer accepts rx_data
parity_err  out  1  parity error on held character
frame_err  out  1  stop bit low on held character
break_det  out  1  pulse: break condition detected
overrun  out  1  sticky: character lost; cleared by rx_ack
RxD_idle  out  1  no start bit for GAP_BITS bit-times
RxD_endofpacket  out  1  one-clk pulse when RxD_idle rises

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, named as the codebase does (clk, rst_n). All outputs reset to 0. The synchroniser and filter reset to 1. The FSM resets to IDLE. The accumulator and counters reset to 0.
- Tick generator: 32-bit accumulator adds BAUD*OVERSAMPLING each clk. When the sum is >= CLK_FREQ, subtract CLK_FREQ and assert tick for that clk. Average tick rate is exact.
- Input conditioning: 2-FF synchroniser clocked every clk.
  - On each tick, shift the synchronised value into a 3-sample window.
  - The filtered bit is the majority of the 3 samples.
- Phase counter: log2(OVERSAMPLING) bits.
  - Cleared in IDLE.
  - Increments on tick otherwise.
  - Sample point is the tick where the counter equals OVERSAMPLING/2-1, then every OVERSAMPLING ticks after that.
- FSM states:
  - IDLE: filtered bit 0 -> START.
  - START: at the sample point, filtered bit 1 -> IDLE (false start, no outputs). Otherwise -> DATA.
  - DATA: shift DATA_BITS samples, LSB first. Then -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: sample one bit; compute error = (XOR of data ^ parity bit) != (PARITY == 1).
  - STOP: sample STOP_BITS bits. Any 0 sets frame_err for this character. After the last stop sample:
    - if all data, parity and stop samples were 0 -> BREAK;
    - else -> IDLE.
  - BREAK: wait for filtered bit 1, then -> IDLE.
- Delivery: one clk after the last stop sample.
  - If rx_valid = 0: load rx_data, parity_err and frame_err; set rx_valid.
  - If rx_valid = 1 and rx_ack is not asserted that same clk: discard the new character, keep the old one, set overrun.
  - Break characters are never delivered. Instead, break_det pulses for 1 clk when entering BREAK.
- Handshake:
  - rx_ack while rx_valid clears rx_valid, parity_err, frame_err and overrun next clk.
  - rx_ack in the same clk as a delivery: the new character is loaded with no overrun.
  - rx_ack with rx_valid = 0 is ignored.
- Idle/gap:
  - Gap counter cleared whenever FSM != IDLE.
  - In IDLE it increments on tick and saturates at GAP_BITS*OVERSAMPLING.
  - RxD_idle = saturated.
  - RxD_endofpacket pulses on the clk the counter reaches saturation.
  - After reset, RxD_idle asserts only after a full gap.
- Line stuck low from reset: first character ends as a break; no data is delivered.
- Reset mid-character: the partial character is dropped and no outputs are set. Reception restarts with the next falling edge after release.

Test Plan:
- Sim params CLK_FREQ=1600000, BAUD=100000, OVERSAMPLING=16 (tick every clk, 16 clk/bit). Send 8N1 0xA5 -> rx_valid rises ~1 clk after centre of stop (~152 clk after start edge); rx_data=0xA5; both error flags 0.
- DATA_BITS=7, PARITY=2. Send 0x41 with parity bit 0 -> parity_err=0. Resend with parity 1 -> parity_err=1, rx_data=0x41.
- 8N1 with stop bit driven 0 -> frame_err=1. Line held low for 20 bit-times -> break_det one pulse; rx_valid stays 0; next 0x55 received cleanly.
- Send 0x11 then 0x22 with rx_ack low -> rx_data=0x11, overrun=1. rx_ack pulse -> rx_valid=0, overrun=0. Ack coinciding with a delivery -> new byte, overrun stays 0.
- 6-clk low glitch on RxD -> no rx_valid, FSM back to IDLE. After last byte, line high for 32 clk -> RxD_idle=1 and RxD_endofpacket single pulse.
- Assert rst_n low mid-byte -> all outputs 0 immediately. Full byte 0x3C sent after release -> received correctly.
